ifft_frame_ctrl: RTL

Frames a stream of mapped subcarrier symbols into N-point blocks for the OFDM transmitter IFFT core. It inserts null bins (DC and guard band) and drives the core's sink handshake with sop/eop. It also monitors the core's source stream for framing errors and captures the block exponent per output frame. The block sits between the QAM mapper and the IFFT core, and feeds status to the cyclic-prefix stage and control registers.

---
 rtl/ifft_frame_ctrl.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/ifft_frame_ctrl.sv
// Frames mapper symbols into FFT_LEN-point IFFT input blocks with DC/guard nulls,
// and watches the IFFT core's output stream for framing errors and block exponents.
module ifft_frame_ctrl #(
   parameter int FFT_LEN = 64,
   parameter int NULL_LO = 27,
   parameter int NULL_HI = 37,
   parameter int DW      = 8
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          enable,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] in_real,
   input  logic [DW-1:0] in_imag,
   output logic          fft_sink_valid,
   input  logic          fft_sink_ready,
   output logic          fft_sink_sop,
   output logic          fft_sink_eop,
   output logic [DW-1:0] fft_sink_real,
   output logic [DW-1:0] fft_sink_imag,
   output logic [1:0]    fft_sink_error,
   output logic          fft_inverse,
   input  logic          fft_source_valid,
   input  logic          fft_source_ready,
   input  logic          fft_source_sop,
   input  logic          fft_source_eop,
   input  logic [1:0]    fft_source_error,
   input  logic [5:0]    fft_source_exp,
   output logic          frame_done,
   output logic [15:0]   frame_cnt,
   output logic [5:0]    exp_last,
   output logic          err_sticky,
   input  logic          clr_err
);

   localparam int            KW     = $clog2(FFT_LEN);
   localparam logic [KW-1:0] K_LAST = KW'(FFT_LEN - 1);
   localparam logic [KW-1:0] K_NLO  = KW'(NULL_LO);
   localparam logic [KW-1:0] K_NHI  = KW'(NULL_HI);

   typedef enum logic {ST_IDLE, ST_FEED} state_t;

   state_t        r_state;
   logic [KW-1:0] r_k;
   logic          r_valid, r_sop, r_eop;
   logic [DW-1:0] r_real, r_imag;

   logic          w_null, w_load, w_adv;

   always_comb begin
      w_null = (r_k == '0) || ((r_k >= K_NLO) && (r_k <= K_NHI));
      w_load = (r_state == ST_FEED) && (!r_valid || fft_sink_ready);
      w_adv  = w_load && (w_null || in_valid);
   end

   // in_ready depends only on state, k and the output register: never on in_valid
   assign in_ready       = w_load && !w_null;
   assign fft_sink_valid = r_valid;
   assign fft_sink_sop   = r_sop;
   assign fft_sink_eop   = r_eop;
   assign fft_sink_real  = r_real;
   assign fft_sink_imag  = r_imag;
   assign fft_sink_error = 2'b00;
   assign fft_inverse    = 1'b1;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= ST_IDLE;
         r_k     <= '0;
         r_valid <= 1'b0;
         r_sop   <= 1'b0;
         r_eop   <= 1'b0;
         r_real  <= '0;
         r_imag  <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               // drain the final bin of the last frame
               if (fft_sink_ready)
                  r_valid <= 1'b0;
               if (enable) begin
                  r_state <= ST_FEED;
                  r_k     <= '0;
               end
            end
            ST_FEED: begin
               if (w_load) begin
                  if (w_adv) begin
                     r_valid <= 1'b1;
                     r_sop   <= (r_k == '0);
                     r_eop   <= (r_k == K_LAST);
                     r_real  <= w_null ? '0 : in_real;
                     r_imag  <= w_null ? '0 : in_imag;
                     r_k     <= r_k + KW'(1);
                     if ((r_k == K_LAST) && !enable)
                        r_state <= ST_IDLE;
                  end else begin
                     r_valid <= 1'b0;
                  end
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   logic [KW-1:0] r_oc;
   logic          w_beat, w_err;

   always_comb begin
      w_beat = fft_source_valid && fft_source_ready;
      w_err  = w_beat && ((fft_source_sop && (r_oc != '0)) ||
                          (!fft_source_sop && (r_oc == '0)) ||
                          (fft_source_eop && (r_oc != K_LAST)) ||
                          (!fft_source_eop && (r_oc == K_LAST)) ||
                          (fft_source_error != 2'b00));
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_oc       <= '0;
         frame_done <= 1'b0;
         frame_cnt  <= '0;
         exp_last   <= '0;
         err_sticky <= 1'b0;
      end else begin
         frame_done <= w_beat && fft_source_eop;
         if (w_beat) begin
            if (fft_source_eop) begin
               r_oc      <= '0;
               exp_last  <= fft_source_exp;
               frame_cnt <= frame_cnt + 16'd1;
            end else if (fft_source_sop) begin
               r_oc <= KW'(1);
            end else begin
               r_oc <= r_oc + KW'(1);
            end
         end
         // a fresh error outranks a simultaneous clear
         if (w_err)
            err_sticky <= 1'b1;
         else if (clr_err)
            err_sticky <= 1'b0;
      end
   end

endmodule
